// File: rtl/r2r_pkg.sv
// Shared constants and result record for the R2R channel processor.
package r2r_pkg;

  localparam int MAX_MV_DEFAULT = 3300;
  localparam int MV_W           = 16;
  localparam int CH_W_MAX       = 4;
  localparam int CODE_W_MAX     = 16;

  typedef struct packed {
    logic [CH_W_MAX-1:0]   ch;
    logic [CODE_W_MAX-1:0] code;
    logic [MV_W-1:0]       mv;
    logic                  sat;
  } r2r_result_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r2r_block_accum.sv
// One channel's block accumulator: running sum plus sample count.
module r2r_block_accum #(
  parameter int DATA_W    = 8,
  parameter int AVG_POWER = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              avg_en,
  input  logic [DATA_W-1:0] in_data,
  output logic              emit,
  output logic [DATA_W-1:0] code
);

  localparam int ACC_W = DATA_W + AVG_POWER;
  localparam int CNT_W = (AVG_POWER > 0) ? AVG_POWER : 1;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  // The completing sample is folded into the emitted average directly,
  // so the block clears on the same edge it emits.
  always_comb begin
    sum   = acc_q + ACC_W'(in_data);
    full  = (AVG_POWER == 0) || (cnt_q == '1);
    emit  = !avg_en || full;
    code  = avg_en ? DATA_W'(sum >> AVG_POWER) : in_data;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (sample_en) begin
      if (emit) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/r2r_channel_processor.sv
// Time-multiplexed R2R sample averager with millivolt scaling and clamp.
module r2r_channel_processor
  import r2r_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int AVG_POWER = 2,
  parameter int SCALE     = 3300,
  parameter int SHIFT     = 8,
  parameter int MAX_MV    = MAX_MV_DEFAULT,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              avg_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [MV_W-1:0]   out_mv,
  output logic [DATA_W-1:0] out_avg,
  output logic              sat,
  output logic [15:0]       sat_count,
  output logic              ch_err
);

  localparam int PROD_W = DATA_W + 32;

  logic              adv, accept, ch_legal;
  logic [NUM_CH-1:0] sample_en, emit_vec;
  logic [DATA_W-1:0] code_arr [NUM_CH];
  logic              sel_emit;
  logic [DATA_W-1:0] sel_code;

  logic              s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
  logic [DATA_W-1:0] s1_code_q, s1_code_d;

  logic              out_valid_q, out_valid_d;
  r2r_result_t       res_q, res_d;
  logic [15:0]       sat_count_q, sat_count_d;
  logic              ch_err_q, ch_err_d;

  logic [PROD_W-1:0] prod, scaled;
  logic              clamp;
  logic              unused_res;

  if ((1 << CH_W) == NUM_CH) begin : g_all_legal
    assign ch_legal = 1'b1;
  end else begin : g_range_check
    assign ch_legal = (32'(in_ch) < NUM_CH);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    r2r_block_accum #(
      .DATA_W    (DATA_W),
      .AVG_POWER (AVG_POWER)
    ) u_accum (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en[c]),
      .avg_en    (avg_en),
      .in_data   (in_data),
      .emit      (emit_vec[c]),
      .code      (code_arr[c])
    );
  end

  always_comb begin
    adv    = !out_valid_q || out_ready;
    accept = in_valid && adv;
  end

  // Channel demux: only a legal channel's accumulator sees the sample.
  always_comb begin
    sample_en = '0;
    sel_emit  = 1'b0;
    sel_code  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (in_ch == CH_W'(c)) begin
        sample_en[c] = accept && ch_legal;
        sel_emit     = emit_vec[c];
        sel_code     = code_arr[c];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ch_d     = s1_ch_q;
    s1_code_d   = s1_code_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    sat_count_d = sat_count_q;
    ch_err_d    = ch_err_q || (accept && !ch_legal);

    prod   = PROD_W'(s1_code_q) * PROD_W'(SCALE);
    scaled = prod >> SHIFT;
    clamp  = scaled > PROD_W'(MAX_MV);

    if (adv) begin
      s1_valid_d  = accept && ch_legal && sel_emit;
      s1_ch_d     = in_ch;
      s1_code_d   = sel_code;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d.ch   = CH_W_MAX'(s1_ch_q);
        res_d.code = CODE_W_MAX'(s1_code_q);
        res_d.mv   = clamp ? MV_W'(MAX_MV) : scaled[MV_W-1:0];
        res_d.sat  = clamp;
        if (clamp && (sat_count_q != '1)) begin
          sat_count_d = sat_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_code_q   <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sat_count_q <= '0;
      ch_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_code_q   <= s1_code_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      sat_count_q <= sat_count_d;
      ch_err_q    <= ch_err_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_ch     = res_q.ch[CH_W-1:0];
  assign out_avg    = res_q.code[DATA_W-1:0];
  assign out_mv     = res_q.mv;
  assign sat        = res_q.sat;
  assign sat_count  = sat_count_q;
  assign ch_err     = ch_err_q;
  assign unused_res = ^{res_q.ch, res_q.code};

endmodule

// File: tb/tb_r2r_channel_processor.sv
// Bench for r2r_channel_processor: vector table, directed corners, random vs model.
module tb_r2r_channel_processor;

  localparam int M_NUM_CH = 3;
  localparam int M_AVGP   = 2;
  localparam int M_SCALE  = 3300;
  localparam int M_SHIFT  = 8;
  localparam int M_MAX    = 3300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        m_in_valid, m_in_ready, m_avg_en, m_out_valid, m_out_ready;
  logic [1:0]  m_in_ch, m_out_ch;
  logic [7:0]  m_in_data, m_out_avg;
  logic [15:0] m_out_mv, m_sat_count;
  logic        m_sat, m_ch_err;

  logic        s_in_valid, s_in_ready, s_avg_en, s_out_valid, s_out_ready;
  logic [1:0]  s_in_ch, s_out_ch;
  logic [7:0]  s_in_data, s_out_avg;
  logic [15:0] s_out_mv, s_sat_count;
  logic        s_sat, s_ch_err;

  r2r_channel_processor #(
    .NUM_CH (M_NUM_CH)
  ) u_main (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_ch     (m_in_ch),
    .in_data   (m_in_data),
    .avg_en    (m_avg_en),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_ch    (m_out_ch),
    .out_mv    (m_out_mv),
    .out_avg   (m_out_avg),
    .sat       (m_sat),
    .sat_count (m_sat_count),
    .ch_err    (m_ch_err)
  );

  r2r_channel_processor #(
    .SCALE (3400)
  ) u_sat (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_ch     (s_in_ch),
    .in_data   (s_in_data),
    .avg_en    (s_avg_en),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_ch    (s_out_ch),
    .out_mv    (s_out_mv),
    .out_avg   (s_out_avg),
    .sat       (s_sat),
    .sat_count (s_sat_count),
    .ch_err    (s_ch_err)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: block sums per channel, queue of expected results.
  typedef struct { int ch; int avg; int mv; bit sat; } res_t;
  res_t exp_q[$];
  int   sums [M_NUM_CH];
  int   cnts [M_NUM_CH];

  function automatic void push_result(input int ch, input int code);
    res_t r;
    int   p;
    p     = (code * M_SCALE) / (1 << M_SHIFT);
    r.ch  = ch;
    r.avg = code;
    r.sat = (p > M_MAX);
    r.mv  = r.sat ? M_MAX : p;
    exp_q.push_back(r);
  endfunction

  function automatic void model_accept(input int ch, input int data, input bit avg);
    if (ch >= M_NUM_CH) return;
    if (!avg || M_AVGP == 0) begin
      sums[ch] = 0;
      cnts[ch] = 0;
      push_result(ch, data);
    end else begin
      sums[ch] += data;
      cnts[ch]++;
      if (cnts[ch] == (1 << M_AVGP)) begin
        push_result(ch, sums[ch] / (1 << M_AVGP));
        sums[ch] = 0;
        cnts[ch] = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < M_NUM_CH; i++) begin
        sums[i] = 0;
        cnts[i] = 0;
      end
    end else begin
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("mon_ch", m_out_ch, e.ch);
          chk("mon_avg", m_out_avg, e.avg);
          chk("mon_mv", m_out_mv, e.mv);
          chk("mon_sat", m_sat, e.sat);
        end
      end
      if (m_in_valid && m_in_ready) model_accept(int'(m_in_ch), int'(m_in_data), m_avg_en);
    end
  end

  typedef struct { bit avg_en; int ch; int data; bit emit; int avg; int mv; bit sat; } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit a, input int ch, input int d, input bit e,
                              input int avg, input int mv, input bit s);
    vec_t v;
    v.avg_en = a; v.ch = ch; v.data = d; v.emit = e; v.avg = avg; v.mv = mv; v.sat = s;
    return v;
  endfunction

  task automatic apply_sample(input string name, input vec_t v);
    @(posedge clk); #1;
    m_out_ready = 1'b1;
    m_in_valid  = 1'b1;
    m_in_ch     = 2'(v.ch);
    m_in_data   = 8'(v.data);
    m_avg_en    = v.avg_en;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    chk({name, "_lat1_valid"}, m_out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_lat2_valid"}, m_out_valid, v.emit);
    if (v.emit) begin
      chk({name, "_ch"}, m_out_ch, v.ch);
      chk({name, "_avg"}, m_out_avg, v.avg);
      chk({name, "_mv"}, m_out_mv, v.mv);
      chk({name, "_sat"}, m_sat, v.sat);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    m_in_valid  = 1'b0;
    s_in_valid  = 1'b0;
    m_out_ready = 1'b0;
    s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_out_mv", m_out_mv, 0);
    chk("rst_out_avg", m_out_avg, 0);
    chk("rst_out_ch", m_out_ch, 0);
    chk("rst_sat", m_sat, 0);
    chk("rst_sat_count", m_sat_count, 0);
    chk("rst_ch_err", m_ch_err, 0);
    chk("rst_s_sat_count", s_sat_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", m_in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    m_in_valid = 1'b0; m_in_ch = '0; m_in_data = '0; m_avg_en = 1'b0; m_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_ch = '0; s_in_data = '0; s_avg_en = 1'b0; s_out_ready = 1'b0;

    tbl.push_back(mk(0, 0, 128, 1, 128, 1650, 0));
    tbl.push_back(mk(0, 1, 0,   1, 0,   0,    0));
    tbl.push_back(mk(0, 2, 255, 1, 255, 3287, 0));
    tbl.push_back(mk(0, 0, 1,   1, 1,   12,   0));
    tbl.push_back(mk(0, 1, 200, 1, 200, 2578, 0));
    tbl.push_back(mk(1, 2, 10,  0, 0,   0,    0));
    tbl.push_back(mk(1, 2, 20,  0, 0,   0,    0));
    tbl.push_back(mk(1, 2, 30,  0, 0,   0,    0));
    tbl.push_back(mk(1, 2, 40,  1, 25,  322,  0));
    tbl.push_back(mk(0, 3, 50,  0, 0,   0,    0));
    tbl.push_back(mk(1, 0, 4,   0, 0,   0,    0));
    tbl.push_back(mk(1, 1, 100, 0, 0,   0,    0));
    tbl.push_back(mk(1, 0, 8,   0, 0,   0,    0));
    tbl.push_back(mk(1, 1, 101, 0, 0,   0,    0));
    tbl.push_back(mk(1, 0, 12,  0, 0,   0,    0));
    tbl.push_back(mk(1, 1, 102, 0, 0,   0,    0));
    tbl.push_back(mk(1, 0, 16,  1, 10,  128,  0));
    tbl.push_back(mk(1, 1, 103, 1, 101, 1301, 0));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      apply_sample($sformatf("vec%0d", i), tbl[i]);
    end
    chk("illegal_ch_err", m_ch_err, 1);

    // Back-pressure: two samples fill the pipe, third waits for out_ready.
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    m_avg_en    = 1'b0;
    m_in_ch     = 2'd0;
    m_in_data   = 8'd40;
    m_in_valid  = 1'b1;
    @(posedge clk); #1;
    m_in_data = 8'd41;
    @(posedge clk); #1;
    m_in_data = 8'd42;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", i), m_in_ready, 0);
      chk($sformatf("stall%0d_valid", i), m_out_valid, 1);
      chk($sformatf("stall%0d_avg", i), m_out_avg, 40);
      chk($sformatf("stall%0d_mv", i), m_out_mv, 515);
    end
    @(posedge clk); #1;
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_no_loss", exp_q.size(), 0);
    chk("stall_drained_valid", m_out_valid, 0);

    // Reset in the middle of a ch1 block.
    apply_sample("pre_rst0", mk(1, 1, 7, 0, 0, 0, 0));
    apply_sample("pre_rst1", mk(1, 1, 9, 0, 0, 0, 0));
    do_reset();
    apply_sample("post_rst0", mk(1, 1, 100, 0, 0,   0,    0));
    apply_sample("post_rst1", mk(1, 1, 100, 0, 0,   0,    0));
    apply_sample("post_rst2", mk(1, 1, 100, 0, 0,   0,    0));
    apply_sample("post_rst3", mk(1, 1, 100, 1, 100, 1289, 0));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      m_in_valid  = ($urandom % 4) != 0;
      m_in_ch     = 2'($urandom % 4);
      m_in_data   = 8'($urandom);
      m_avg_en    = ($urandom % 5) != 0;
      m_out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drain_empty", exp_q.size(), 0);

    // Clamp and saturating counter on the SCALE=3400 instance.
    @(posedge clk); #1;
    s_out_ready = 1'b1;
    s_avg_en    = 1'b0;
    s_in_ch     = 2'd0;
    s_in_data   = 8'd255;
    s_in_valid  = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat_valid", s_out_valid, 1);
    chk("sat_mv", s_out_mv, 3300);
    chk("sat_flag", s_sat, 1);
    chk("sat_count1", s_sat_count, 1);
    chk("sat_avg", s_out_avg, 255);
    chk("sat_ch", s_out_ch, 0);
    @(posedge clk); #1;
    s_in_data  = 8'd200;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("nosat_mv", s_out_mv, 2656);
    chk("nosat_flag", s_sat, 0);
    chk("nosat_count", s_sat_count, 1);
    @(posedge clk); #1;
    s_in_data  = 8'd255;
    s_in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_count_hold", s_sat_count, 65535);
    chk("sat_in_ready", s_in_ready, 1);
    chk("sat_ch_err", s_ch_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
